// File: rtl/float_multiple_if.sv
// rtl/float_multiple_if.sv - operand/result bundle for the half-precision multiplier
interface float_multiple_if #(
  parameter int float_width = 16
);
  logic                   in_valid;
  logic [float_width-1:0] float_a;
  logic [float_width-1:0] float_b;
  logic [float_width-1:0] res;
  logic                   out_valid;

  modport master (
    output in_valid, float_a, float_b,
    input  res, out_valid
  );

  modport slave (
    input  in_valid, float_a, float_b,
    output res, out_valid
  );
endinterface

// File: rtl/float_multiple.sv
// rtl/float_multiple.sv - registered binary16 multiplier, flush-to-zero, round-to-nearest-even
module float_multiple #(
  parameter int float_width    = 16,
  parameter int exponent_width = 5,
  parameter int mantissa_width = 10
) (
  input logic             clk,
  input logic             rst,
  float_multiple_if.slave bus
);

  localparam int mw      = mantissa_width;
  localparam int ew      = exponent_width + 3;
  localparam int bias_i  = (1 << (exponent_width - 1)) - 1;
  localparam int emax_i  = (1 << exponent_width) - 1;

  localparam logic [ew-1:0]          bias_v  = bias_i[ew-1:0];
  localparam logic [exponent_width-1:0] emax_v = emax_i[exponent_width-1:0];
  localparam logic [float_width-1:0] nan_v   = {1'b0, emax_v, 1'b1, {(mw-1){1'b0}}};

  logic                      sign;
  logic [exponent_width-1:0] ea, eb;
  logic [mw-1:0]             ma, mb;
  logic                      a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [mw:0]               sig_a, sig_b;
  logic [2*mw+1:0]           product;
  logic                      shift;
  logic [mw-1:0]             kept;
  logic                      guard, sticky, round_up;
  logic [mw:0]               rounded;
  logic signed [ew-1:0]      exp_sum;
  logic [float_width-1:0]    product_res;

  // unpack, multiply, normalize, round and pick the special-case result
  always_comb begin
    sign   = bus.float_a[float_width-1] ^ bus.float_b[float_width-1];
    ea     = bus.float_a[float_width-2:mw];
    eb     = bus.float_b[float_width-2:mw];
    ma     = bus.float_a[mw-1:0];
    mb     = bus.float_b[mw-1:0];

    a_nan  = (ea == emax_v) && (ma != '0);
    b_nan  = (eb == emax_v) && (mb != '0);
    a_inf  = (ea == emax_v) && (ma == '0);
    b_inf  = (eb == emax_v) && (mb == '0);
    // exponent 0 covers both true zero and subnormals, which are flushed
    a_zero = (ea == '0);
    b_zero = (eb == '0);

    sig_a   = {1'b1, ma};
    sig_b   = {1'b1, mb};
    product = sig_a * sig_b;

    // product of two [1,2) significands lies in [1,4); bit 2*mw+1 means >= 2
    shift = product[2*mw+1];
    if (shift) begin
      kept   = product[2*mw:mw+1];
      guard  = product[mw];
      sticky = |product[mw-1:0];
    end else begin
      kept   = product[2*mw-1:mw];
      guard  = product[mw-1];
      sticky = |product[mw-2:0];
    end

    round_up = guard & (sticky | kept[0]);
    rounded  = {1'b0, kept} + {{mw{1'b0}}, round_up};

    // a carry out of the mantissa leaves rounded[mw-1:0] at zero, i.e. 1.0 x 2^(e+1)
    exp_sum = $signed({3'b000, ea} + {3'b000, eb} - bias_v
              + {{(ew-1){1'b0}}, shift} + {{(ew-1){1'b0}}, rounded[mw]});

    if (a_nan || b_nan) begin
      product_res = nan_v;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      product_res = nan_v;
    end else if (a_inf || b_inf) begin
      product_res = {sign, emax_v, {mw{1'b0}}};
    end else if (a_zero || b_zero) begin
      product_res = {sign, {(float_width-1){1'b0}}};
    end else if (exp_sum >= $signed(ew'(emax_i))) begin
      product_res = {sign, emax_v, {mw{1'b0}}};
    end else if (exp_sum <= $signed({ew{1'b0}})) begin
      product_res = {sign, {(float_width-1){1'b0}}};
    end else begin
      product_res = {sign, exp_sum[exponent_width-1:0], rounded[mw-1:0]};
    end
  end

  // capture the product when operands are valid, otherwise hold res and drop out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.res <= product_res;
      end
    end
  end

endmodule

// File: tb/tb_float_multiple.sv
// tb/tb_float_multiple.sv - directed self-checking bench for float_multiple
module tb_float_multiple;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  float_multiple_if bus ();

  float_multiple dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // present one operand pair, clock it, and check the registered product
  task automatic mul_step(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] expv);
    bus.in_valid = 1'b1;
    bus.float_a  = a;
    bus.float_b  = b;
    @(posedge clk);
    #1;
    check16(tag, bus.res, expv);
    check1({tag, "_valid"}, bus.out_valid, 1'b1);
  endtask

  logic [15:0] va [15];
  logic [15:0] vb [15];
  logic [15:0] vr [15];
  string       vt [15];

  initial begin
    checks   = 0;
    failures = 0;

    va[0]  = 16'h3108; vb[0]  = 16'h4003; vr[0]  = 16'h350C; vt[0]  = "guard_sticky_up";
    va[1]  = 16'h6444; vb[1]  = 16'h3333; vr[1]  = 16'h5BAD; vt[1]  = "round_down";
    va[2]  = 16'h3333; vb[2]  = 16'h7777; vr[2]  = 16'h6EB8; vt[2]  = "norm_shift_up";
    va[3]  = 16'h2222; vb[3]  = 16'h8888; vr[3]  = 16'h8000; vt[3]  = "underflow_negzero";
    va[4]  = 16'h6444; vb[4]  = 16'h6666; vr[4]  = 16'h7C00; vt[4]  = "overflow_inf";
    va[5]  = 16'h7C00; vb[5]  = 16'h0000; vr[5]  = 16'h7E00; vt[5]  = "inf_times_zero";
    va[6]  = 16'hFC00; vb[6]  = 16'h3C00; vr[6]  = 16'hFC00; vt[6]  = "neg_inf";
    va[7]  = 16'h7E01; vb[7]  = 16'h3C00; vr[7]  = 16'h7E00; vt[7]  = "nan_canon";
    va[8]  = 16'h0001; vb[8]  = 16'h7000; vr[8]  = 16'h0000; vt[8]  = "subnormal_ftz";
    va[9]  = 16'h8000; vb[9]  = 16'h3C00; vr[9]  = 16'h8000; vt[9]  = "neg_zero";
    va[10] = 16'h3C01; vb[10] = 16'h3C01; vr[10] = 16'h3C02; vt[10] = "small_sticky";
    va[11] = 16'h3BFF; vb[11] = 16'h4000; vr[11] = 16'h3FFF; vt[11] = "exact";
    va[12] = 16'h3FFF; vb[12] = 16'h3FFF; vr[12] = 16'h43FE; vt[12] = "norm_then_round";
    va[13] = 16'h7BFF; vb[13] = 16'h3C01; vr[13] = 16'h7C00; vt[13] = "round_carry_inf";
    va[14] = 16'h5000; vb[14] = 16'hC400; vr[14] = 16'hD800; vt[14] = "neg_power_of_two";

    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.float_a  = '0;
    bus.float_b  = '0;

    // asynchronous reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    check16("rst_async_res", bus.res, 16'h0000);
    check1("rst_async_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check1("idle_after_rst_valid", bus.out_valid, 1'b0);
    check16("idle_after_rst_res", bus.res, 16'h0000);

    // back-to-back directed vectors
    for (int i = 0; i < 15; i++) begin
      mul_step(vt[i], va[i], vb[i], vr[i]);
    end

    // in_valid low: out_valid drops, res holds the last product
    bus.in_valid = 1'b0;
    bus.float_a  = 16'h3C00;
    bus.float_b  = 16'h3C00;
    @(posedge clk);
    #1;
    check1("hold_valid", bus.out_valid, 1'b0);
    check16("hold_res", bus.res, vr[14]);

    // stream with reset landing during the third operand cycle
    mul_step("stream1", va[0], vb[0], vr[0]);
    mul_step("stream2", va[1], vb[1], vr[1]);
    bus.in_valid = 1'b1;
    bus.float_a  = va[2];
    bus.float_b  = vb[2];
    #3 rst = 1'b1;
    #1;
    check16("mid_rst_res", bus.res, 16'h0000);
    check1("mid_rst_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    check16("third_discarded_res", bus.res, 16'h0000);
    check1("third_discarded_valid", bus.out_valid, 1'b0);
    rst = 1'b0;
    mul_step("stream4", va[3], vb[3], vr[3]);
    mul_step("stream5", va[4], vb[4], vr[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
